// File: rtl/fake_n64_console_rx.sv
// Joybus console-frame receiver: decodes the command (and optional address) sent by the console.
// Define FAKE_N64_ADDR_CAPTURE_EN to capture the 16-bit address of READ/WRITE (8'h02/8'h03) frames.
`timescale 1ns/1ps
module fake_n64_console_rx #(
   parameter int unsigned LEVEL_WIDTH  = 2,
   parameter int unsigned IDLE_TIMEOUT = 2 * (4 * LEVEL_WIDTH)
) (
   input  logic        sample_clk,
   input  logic        reset_n,
   input  logic        rx_enable,
   input  logic        data_rx,
   output logic [7:0]  cmd,
   output logic [15:0] addr,
   output logic        cmd_valid,
   output logic        tx_handoff,
   output logic        frame_error,
   output logic        rx_busy
);

   localparam int unsigned BIT_WIDTH = 4 * LEVEL_WIDTH;
   localparam int unsigned LOW_CW    = $clog2(BIT_WIDTH + 1);
   localparam int unsigned HIGH_CW   = $clog2(IDLE_TIMEOUT + 1);
   localparam int unsigned FRAME_W   = 24;
   localparam int unsigned IDX_W     = 5;
   localparam int unsigned BCNT_W    = 9;
   localparam int unsigned BCNT_MAX  = 511;

   typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_ERROR} state_e;

   state_e               state_q, state_d;
   logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [LOW_CW-1:0]    low_cnt_q, low_cnt_d;
   logic [HIGH_CW-1:0]   high_cnt_q, high_cnt_d;
   logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic                 pend_q, pend_d;
   logic [7:0]           cmd_q, cmd_d;
   logic [15:0]          addr_q, addr_d;
   logic                 cmd_valid_q, cmd_valid_d;
   logic                 tx_handoff_q, tx_handoff_d;
   logic                 frame_error_q, frame_error_d;
   logic                 rx_busy_q, rx_busy_d;
   logic                 fall, rise, len_ok;
   logic [IDX_W-1:0]     frame_idx;

   // Edges are taken from the synchronized level against its one-cycle-delayed copy
   assign fall = prev_q & ~sync2_q;
   assign rise = ~prev_q & sync2_q;

`ifdef FAKE_N64_ADDR_CAPTURE_EN
   logic is_rw;
   always_comb begin
      is_rw  = (frame_q[FRAME_W-1 -: 8] == 8'h02) || (frame_q[FRAME_W-1 -: 8] == 8'h03);
      len_ok = is_rw ? (bit_cnt_q >= BCNT_W'(FRAME_W)) : (bit_cnt_q == BCNT_W'(8));
   end
`else
   always_comb len_ok = (bit_cnt_q >= BCNT_W'(8));
`endif

   always_comb begin
      sync1_d       = data_rx;
      sync2_d       = sync1_q;
      prev_d        = sync2_q;
      state_d       = state_q;
      low_cnt_d     = low_cnt_q;
      high_cnt_d    = high_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      frame_d       = frame_q;
      pend_d        = pend_q;
      cmd_d         = cmd_q;
      addr_d        = addr_q;
      cmd_valid_d   = 1'b0;
      tx_handoff_d  = tx_handoff_q;
      frame_error_d = 1'b0;
      frame_idx     = IDX_W'(FRAME_W - 1) - bit_cnt_q[IDX_W-1:0];

      if (!rx_enable) begin
         state_d    = ST_IDLE;
         low_cnt_d  = '0;
         high_cnt_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (fall) begin
                  state_d    = ST_LOW;
                  low_cnt_d  = LOW_CW'(1);
                  high_cnt_d = '0;
                  bit_cnt_d  = '0;
                  frame_d    = '0;
               end
            end
            ST_LOW: begin
               if (rise) begin
                  pend_d     = (low_cnt_q < LOW_CW'(2 * LEVEL_WIDTH));
                  state_d    = ST_HIGH;
                  high_cnt_d = HIGH_CW'(1);
               end else if (low_cnt_q == LOW_CW'(BIT_WIDTH - 1)) begin
                  state_d       = ST_ERROR;
                  frame_error_d = 1'b1;
                  high_cnt_d    = '0;
               end else begin
                  low_cnt_d = low_cnt_q + LOW_CW'(1);
               end
            end
            ST_HIGH: begin
               // Timeout wins over a coincident falling edge; the pending bit is the stop bit
               if (high_cnt_q == HIGH_CW'(IDLE_TIMEOUT - 1)) begin
                  state_d = ST_IDLE;
                  if (pend_q && len_ok) begin
                     cmd_d        = frame_q[FRAME_W-1 -: 8];
`ifdef FAKE_N64_ADDR_CAPTURE_EN
                     if (is_rw) addr_d = frame_q[15:0];
`endif
                     cmd_valid_d  = 1'b1;
                     tx_handoff_d = ~tx_handoff_q;
                  end else begin
                     frame_error_d = 1'b1;
                  end
               end else if (fall) begin
                  if (bit_cnt_q < BCNT_W'(FRAME_W)) frame_d[frame_idx] = pend_q;
                  if (bit_cnt_q != BCNT_W'(BCNT_MAX)) bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                  state_d   = ST_LOW;
                  low_cnt_d = LOW_CW'(1);
               end else begin
                  high_cnt_d = high_cnt_q + HIGH_CW'(1);
               end
            end
            ST_ERROR: begin
               if (!sync2_q) begin
                  high_cnt_d = '0;
               end else if (high_cnt_q == HIGH_CW'(IDLE_TIMEOUT - 1)) begin
                  state_d    = ST_IDLE;
                  high_cnt_d = '0;
               end else begin
                  high_cnt_d = high_cnt_q + HIGH_CW'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      rx_busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge sample_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         prev_q        <= 1'b1;
         low_cnt_q     <= '0;
         high_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         frame_q       <= '0;
         pend_q        <= 1'b0;
         cmd_q         <= 8'h00;
         addr_q        <= 16'h0000;
         cmd_valid_q   <= 1'b0;
         tx_handoff_q  <= 1'b0;
         frame_error_q <= 1'b0;
         rx_busy_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         prev_q        <= prev_d;
         low_cnt_q     <= low_cnt_d;
         high_cnt_q    <= high_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         frame_q       <= frame_d;
         pend_q        <= pend_d;
         cmd_q         <= cmd_d;
         addr_q        <= addr_d;
         cmd_valid_q   <= cmd_valid_d;
         tx_handoff_q  <= tx_handoff_d;
         frame_error_q <= frame_error_d;
         rx_busy_q     <= rx_busy_d;
      end
   end

   assign cmd         = cmd_q;
   assign addr        = addr_q;
   assign cmd_valid   = cmd_valid_q;
   assign tx_handoff  = tx_handoff_q;
   assign frame_error = frame_error_q;
   assign rx_busy     = rx_busy_q;

endmodule

// File: tb/tb_fake_n64_console_rx.sv
// Directed bench for fake_n64_console_rx at LEVEL_WIDTH=2 (BIT_WIDTH=8, IDLE_TIMEOUT=16).
`timescale 1ns/1ps
module tb_fake_n64_console_rx;

   logic        sample_clk = 1'b0;
   logic        reset_n, rx_enable, data_rx;
   logic [7:0]  cmd;
   logic [15:0] addr;
   logic        cmd_valid, tx_handoff, frame_error, rx_busy;

   int checks = 0;
   int errors = 0;
   int cv_cnt = 0, fe_cnt = 0, both_cnt = 0;
   logic exp_tx = 1'b0;

   always #5 sample_clk = ~sample_clk;

   fake_n64_console_rx dut (
      .sample_clk (sample_clk),
      .reset_n    (reset_n),
      .rx_enable  (rx_enable),
      .data_rx    (data_rx),
      .cmd        (cmd),
      .addr       (addr),
      .cmd_valid  (cmd_valid),
      .tx_handoff (tx_handoff),
      .frame_error(frame_error),
      .rx_busy    (rx_busy)
   );

   // Pulse tally, sampled before the edge's updates land
   always @(posedge sample_clk) begin
      if (cmd_valid) cv_cnt++;
      if (frame_error) fe_cnt++;
      if (cmd_valid && frame_error) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      data_rx = v;
      repeat (n) @(posedge sample_clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      if (b) begin hold(1'b0, 2); hold(1'b1, 6); end
      else   begin hold(1'b0, 6); hold(1'b1, 2); end
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   // Stop bit then idle line; samples pulses one cycle early and at IDLE_TIMEOUT+2
   task automatic end_frame(output logic early, output logic cv, output logic fe);
      hold(1'b0, 2);
      data_rx = 1'b1;
      repeat (17) @(posedge sample_clk);
      @(negedge sample_clk);
      early = cmd_valid | frame_error;
      @(posedge sample_clk);
      @(negedge sample_clk);
      cv = cmd_valid;
      fe = frame_error;
      repeat (3) @(posedge sample_clk);
      #1;
   endtask

   logic early, cv, fe;
   int   snap_cv, snap_fe;

   initial begin
      reset_n   = 1'b0;
      rx_enable = 1'b1;
      data_rx   = 1'b1;
      repeat (3) @(posedge sample_clk);
      @(negedge sample_clk);
      chk("rst_cmd", 32'(cmd), 32'h00);
      chk("rst_addr", 32'(addr), 32'h0000);
      chk("rst_cv", 32'(cmd_valid), 32'd0);
      chk("rst_tx", 32'(tx_handoff), 32'd0);
      chk("rst_fe", 32'(frame_error), 32'd0);
      chk("rst_busy", 32'(rx_busy), 32'd0);
      @(posedge sample_clk); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge sample_clk); #1;

      // Command 8'h00 with exact pulse timing
      send_bits(32'h00, 8);
      end_frame(early, cv, fe);
      exp_tx = ~exp_tx;
      chk("c00_early", 32'(early), 32'd0);
      chk("c00_cv", 32'(cv), 32'd1);
      chk("c00_fe", 32'(fe), 32'd0);
      chk("c00_cmd", 32'(cmd), 32'h00);
      chk("c00_tx", 32'(tx_handoff), 32'(exp_tx));
      chk("c00_idle", 32'(rx_busy), 32'd0);

      // Back-to-back 8'h01 then 8'hFF
      snap_cv = cv_cnt;
      send_bits(32'h01, 8);
      end_frame(early, cv, fe);
      exp_tx = ~exp_tx;
      chk("c01_cv", 32'(cv), 32'd1);
      chk("c01_cmd", 32'(cmd), 32'h01);
      chk("c01_tx", 32'(tx_handoff), 32'(exp_tx));
      send_bits(32'hFF, 8);
      end_frame(early, cv, fe);
      exp_tx = ~exp_tx;
      chk("cff_cv", 32'(cv), 32'd1);
      chk("cff_cmd", 32'(cmd), 32'hFF);
      chk("cff_tx", 32'(tx_handoff), 32'(exp_tx));
      chk("b2b_pulses", 32'(cv_cnt - snap_cv), 32'd2);

      // Line stuck low for 8 cycles in bit 3
      snap_fe = fe_cnt;
      send_bits(32'b101, 3);
      hold(1'b0, 8);
      data_rx = 1'b1;
      @(posedge sample_clk); @(negedge sample_clk);
      chk("stuck_fe_pre", 32'(frame_error), 32'd0);
      @(posedge sample_clk); @(negedge sample_clk);
      chk("stuck_fe", 32'(frame_error), 32'd1);
      @(posedge sample_clk); @(negedge sample_clk);
      chk("stuck_fe_once", 32'(frame_error), 32'd0);
      chk("stuck_busy", 32'(rx_busy), 32'd1);
      repeat (14) @(posedge sample_clk);
      @(negedge sample_clk);
      chk("err_wait", 32'(rx_busy), 32'd1);
      @(posedge sample_clk); @(negedge sample_clk);
      chk("err_exit", 32'(rx_busy), 32'd0);
      chk("stuck_tx", 32'(tx_handoff), 32'(exp_tx));
      chk("stuck_fe_cnt", 32'(fe_cnt - snap_fe), 32'd1);
      @(posedge sample_clk); #1;

      // Seven data bits plus stop
      send_bits(32'b1010101, 7);
      end_frame(early, cv, fe);
      chk("short_early", 32'(early), 32'd0);
      chk("short_fe", 32'(fe), 32'd1);
      chk("short_cv", 32'(cv), 32'd0);
      chk("short_cmd", 32'(cmd), 32'hFF);
      chk("short_tx", 32'(tx_handoff), 32'(exp_tx));

      // Reset in the middle of 8'h01, then a clean 8'h00
      send_bits(32'b0000, 4);
      reset_n = 1'b0;
      @(negedge sample_clk);
      chk("mid_rst_cmd", 32'(cmd), 32'h00);
      chk("mid_rst_addr", 32'(addr), 32'h0000);
      chk("mid_rst_tx", 32'(tx_handoff), 32'd0);
      chk("mid_rst_fe", 32'(frame_error), 32'd0);
      chk("mid_rst_cv", 32'(cmd_valid), 32'd0);
      chk("mid_rst_busy", 32'(rx_busy), 32'd0);
      repeat (3) @(posedge sample_clk); #1;
      reset_n = 1'b1;
      exp_tx  = 1'b0;
      repeat (2) @(posedge sample_clk); #1;
      snap_cv = cv_cnt;
      send_bits(32'h00, 8);
      end_frame(early, cv, fe);
      exp_tx = ~exp_tx;
      chk("post_rst_cv", 32'(cv), 32'd1);
      chk("post_rst_cmd", 32'(cmd), 32'h00);
      chk("post_rst_tx", 32'(tx_handoff), 32'(exp_tx));
      chk("post_rst_pulses", 32'(cv_cnt - snap_cv), 32'd1);

      // rx_enable dropped mid-frame: idle, no pulses
      snap_cv = cv_cnt;
      snap_fe = fe_cnt;
      send_bits(32'b110, 3);
      hold(1'b0, 3);
      rx_enable = 1'b0;
      @(negedge sample_clk);
      chk("dis_busy_pre", 32'(rx_busy), 32'd1);
      @(posedge sample_clk); @(negedge sample_clk);
      chk("dis_busy", 32'(rx_busy), 32'd0);
      data_rx = 1'b1;
      repeat (4) @(posedge sample_clk); #1;
      rx_enable = 1'b1;
      repeat (25) @(posedge sample_clk); #1;
      chk("dis_no_cv", 32'(cv_cnt - snap_cv), 32'd0);
      chk("dis_no_fe", 32'(fe_cnt - snap_fe), 32'd0);
      chk("dis_idle", 32'(rx_busy), 32'd0);

      // Nine-bit frame: 8'hA5 plus one extra bit
      send_bits(32'h14B, 9);
      end_frame(early, cv, fe);
`ifdef FAKE_N64_ADDR_CAPTURE_EN
      chk("nine_fe", 32'(fe), 32'd1);
      chk("nine_cmd", 32'(cmd), 32'h00);
`else
      exp_tx = ~exp_tx;
      chk("nine_cv", 32'(cv), 32'd1);
      chk("nine_cmd", 32'(cmd), 32'hA5);
`endif
      chk("nine_tx", 32'(tx_handoff), 32'(exp_tx));

      // READ frame 8'h02 / 16'h8001
      send_bits(32'h028001, 24);
      end_frame(early, cv, fe);
      exp_tx = ~exp_tx;
      chk("rd_cv", 32'(cv), 32'd1);
      chk("rd_cmd", 32'(cmd), 32'h02);
`ifdef FAKE_N64_ADDR_CAPTURE_EN
      chk("rd_addr", 32'(addr), 32'h8001);
`else
      chk("rd_addr", 32'(addr), 32'h0000);
`endif
      chk("rd_tx", 32'(tx_handoff), 32'(exp_tx));

      // Same frame truncated to 16 bits
      send_bits(32'h0280, 16);
      end_frame(early, cv, fe);
`ifdef FAKE_N64_ADDR_CAPTURE_EN
      chk("trunc_fe", 32'(fe), 32'd1);
      chk("trunc_addr", 32'(addr), 32'h8001);
`else
      exp_tx = ~exp_tx;
      chk("trunc_cv", 32'(cv), 32'd1);
      chk("trunc_addr", 32'(addr), 32'h0000);
`endif
      chk("trunc_cmd", 32'(cmd), 32'h02);
      chk("trunc_tx", 32'(tx_handoff), 32'(exp_tx));

      chk("no_overlap", 32'(both_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fake_n64_console_rx.md
FAKE_N64_CONSOLE_RX -- requirements
Module: fake_n64_console_rx

Interface
REQ-001 Parameter LEVEL_WIDTH, default 2, sample_clk cycles per Joybus level; BIT_WIDTH = 4*LEVEL_WIDTH.
REQ-002 Parameter IDLE_TIMEOUT, default 2*BIT_WIDTH, consecutive high cycles that end a frame.
REQ-003 sample_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rx_enable  input  1  1 = Rx phase, receiver armed; 0 = Tx phase, receiver held in IDLE.
REQ-006 data_rx  input  1  raw Joybus line (1 = released/high), asynchronous to sample_clk.
REQ-007 cmd  output  8  first received byte, MSB first; held until the next valid frame.
REQ-008 addr  output  16  bytes 2-3 of a READ/WRITE frame (see Configuration).
REQ-009 cmd_valid  output  1  one-cycle pulse when cmd/addr update.
REQ-010 tx_handoff  output  1  toggles once per valid frame; consumed by the controller Tx stage.
REQ-011 frame_error  output  1  one-cycle pulse on a rejected frame.
REQ-012 rx_busy  output  1  high in every state except IDLE.

Function
REQ-013 data_rx SHALL pass a 2-flop synchronizer; all edge detection uses the synchronized level (2-cycle latency).
REQ-014 States SHALL be IDLE, LOW, HIGH, ERROR.
REQ-015 IDLE: on falling edge with rx_enable=1 -> LOW, low_cnt=1, bit_cnt=0.
REQ-016 LOW: low_cnt increments per low cycle; on rising edge, pending bit = 1 if low_cnt < 2*LEVEL_WIDTH, else 0; -> HIGH, high_cnt=1.
REQ-017 LOW: low_cnt reaching BIT_WIDTH (line stuck low) -> ERROR, frame_error pulse.
REQ-018 HIGH: on falling edge, pending bit SHALL shift into the 24-bit frame register (MSB first), bit_cnt increments (9 bits, saturating at 511), -> LOW, low_cnt=1.
REQ-019 HIGH: high_cnt reaching IDLE_TIMEOUT ends the frame; the pending bit is the console stop bit and is not shifted.
REQ-020 Frame end SHALL be valid only if stop bit = 1 and the bit-count rule (REQ-030/031) holds; valid -> update cmd/addr, pulse cmd_valid, toggle tx_handoff, -> IDLE, all in the same cycle.
REQ-021 Invalid frame end -> frame_error pulse, cmd/addr/tx_handoff unchanged, -> IDLE.
REQ-022 ERROR: SHALL wait until the line is high for IDLE_TIMEOUT consecutive cycles, then -> IDLE; falling edges restart the wait.
REQ-023 rx_enable=0 in any state SHALL force IDLE next cycle with no cmd_valid/frame_error pulse.
REQ-024 A falling edge in the cycle high_cnt reaches IDLE_TIMEOUT SHALL be treated as frame end; the edge is ignored.
REQ-025 cmd_valid and frame_error SHALL never assert in the same cycle.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state IDLE and all counters to 0.
REQ-027 Reset values: cmd=8'h00, addr=16'h0000, cmd_valid=0, tx_handoff=0, frame_error=0, rx_busy=0; synchronizer flops = 1.
REQ-028 Reset mid-frame SHALL discard the partial frame; a complete new frame after release SHALL decode normally.

Configuration
REQ-029 Macro FAKE_N64_ADDR_CAPTURE_EN selects address capture.
REQ-030 Defined: cmd 8'h02/8'h03 require bit_cnt >= 24, addr = frame bits 8..23; all other cmds require bit_cnt == 8; extra bits beyond 24 are counted but not stored.
REQ-031 Undefined: any frame with bit_cnt >= 8 is valid, cmd = first 8 bits, addr held at 16'h0000.

Verification
REQ-032 Cmd 8'h00 (eight 0-bits, L L L H at LEVEL_WIDTH=2) + stop -> cmd=8'h00, cmd_valid pulse IDLE_TIMEOUT+2 cycles after stop rising edge, tx_handoff 0->1.
REQ-033 Cmd 8'h01 then cmd 8'hFF back-to-back -> cmd 8'h01 then 8'hFF, two cmd_valid pulses, tx_handoff 0->1->0.
REQ-034 Line held low 8 cycles in bit 3 -> frame_error pulse, ERROR until 16 high cycles, no tx_handoff toggle.
REQ-035 Only 7 data bits + stop -> frame_error pulse, cmd unchanged.
REQ-036 reset_n pulsed low at bit 4 of cmd 8'h01, then full cmd 8'h00 -> all outputs at reset values during reset, then cmd=8'h00, single tx_handoff toggle.
REQ-037 With FAKE_N64_ADDR_CAPTURE_EN: frame 8'h02, 16'h8001 + stop -> cmd=8'h02, addr=16'h8001; same frame truncated to 16 bits -> frame_error.
